// File: rtl/downsample_2x2.sv
// Streaming 2x2 average-pool downsampler: one rounded mean per non-overlapping
// 2x2 block of a raster-order signed fixed-point pixel stream, valid/ready on both sides.
module downsample_2x2 #(
  parameter int length = 12,
  parameter int frac   = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [length-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [length-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  localparam int LD = 1 << LW;

  if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_w
    $error("downsample_2x2: IMG_W must be even and >= 2");
  end
  if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_h
    $error("downsample_2x2: IMG_H must be even and >= 2");
  end
  if (frac < 0 || frac >= length) begin : g_bad_frac
    $error("downsample_2x2: frac must lie in [0, length)");
  end

  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic signed [length-1:0] hold;
  logic signed [length:0]   linebuf [LD];

  logic                     in_fire;
  logic                     col_last;
  logic                     row_last;
  logic [LW-1:0]            lb_idx;
  logic signed [length:0]   h;
  logic signed [length+1:0] sum;
  logic signed [length+1:0] rnd;
  logic signed [length-1:0] result;

  // A single output register; a drain in the same cycle frees it for a new load.
  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign lb_idx   = LW'(col >> 1);

  // Horizontal pair sum, then vertical sum with the pair stored on the even row.
  assign h      = {hold[length-1], hold} + {in_data[length-1], in_data};
  assign sum    = {linebuf[lb_idx][length], linebuf[lb_idx]} + {h[length], h};
  assign rnd    = sum + (length + 2)'(2);
  // Mean of four in-range samples is in range, so plain truncation is safe.
  assign result = length'(rnd >>> 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (in_fire) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) hold <= in_data;
      end

      if (out_valid && out_ready) out_valid <= 1'b0;

      if (in_fire && col[0] && row[0]) begin
        out_data  <= result;
        out_valid <= 1'b1;
        out_last  <= row_last && col_last;
      end
    end
  end

  // NOTE: the line buffer has no reset; every entry is written on an even row
  // before the odd row reads it, so clearing it would only cost a reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst && in_fire && col[0] && !row[0]) linebuf[lb_idx] <= h;
  end

endmodule

// File: tb/tb_downsample_2x2.sv
// Self-checking bench for downsample_2x2: randomized frames against a block-mean
// reference model, plus directed rounding, backpressure and reset scenarios.
module tb_downsample_2x2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [11:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [11:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;

  logic signed [11:0] s_in_data = '0;
  logic              s_in_valid = 1'b0;
  logic              s_in_ready;
  logic signed [11:0] s_out_data;
  logic              s_out_valid;
  logic              s_out_ready = 1'b1;
  logic              s_out_last;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int frame [64];

  logic [11:0] got_d [$];
  bit          got_l [$];
  logic [11:0] s_got_d [$];
  bit          s_got_l [$];
  int          exp_d [$];
  bit          exp_l [$];

  always #5 clk = ~clk;

  downsample_2x2 #(.length(12), .frac(8), .IMG_W(8), .IMG_H(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  downsample_2x2 #(.length(12), .frac(8), .IMG_W(4), .IMG_H(2)) dut_s (
    .clk(clk), .rst(rst),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_last(s_out_last)
  );

  // Sink behaviour, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Output transfers are recorded mid-cycle, when every signal is settled.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
    end
    if (!rst && s_out_valid && s_out_ready) begin
      s_got_d.push_back(s_out_data);
      s_got_l.push_back(s_out_last);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int floor_div4(input int v);
    int q;
    q = v / 4;
    if ((v % 4) != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  // Reference: mean of each 2x2 block rounded half toward +inf, raster block order.
  task automatic add_expected();
    int s;
    for (int by = 0; by < 4; by++) begin
      for (int bx = 0; bx < 4; bx++) begin
        s = frame[(2*by)*8 + 2*bx] + frame[(2*by)*8 + 2*bx + 1]
          + frame[(2*by+1)*8 + 2*bx] + frame[(2*by+1)*8 + 2*bx + 1];
        exp_d.push_back(floor_div4(s + 2));
        exp_l.push_back(by == 3 && bx == 3);
      end
    end
  endtask

  task automatic random_frame();
    for (int i = 0; i < 64; i++) frame[i] = int'($urandom_range(0, 4095)) - 2048;
  endtask

  task automatic set_block(input int bx, input int by, input int a, input int b,
                           input int c, input int d);
    frame[(2*by)*8 + 2*bx]       = a;
    frame[(2*by)*8 + 2*bx + 1]   = b;
    frame[(2*by+1)*8 + 2*bx]     = c;
    frame[(2*by+1)*8 + 2*bx + 1] = d;
  endtask

  task automatic set_ready(input int mode);
    rdy_mode = mode;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one pixel (after an optional random idle gap) until it is accepted.
  task automatic send(input int px, input int gap_max);
    int  n;
    bit  done;
    if (gap_max > 0) begin
      n = $urandom_range(0, gap_max);
      repeat (n) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = px[11:0];
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got in_ready=%0b for %0d cycles, need 1", in_ready, n);
        done = 1'b1;
      end
    end
  endtask

  task automatic send_range(input int first, input int last, input int gap_max);
    for (int i = first; i <= last; i++) send(frame[i], gap_max);
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int t;
    t = 0;
    while (got_d.size() < n && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (20) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic compare_outputs(input string tag);
    int          t;
    int          n;
    logic [11:0] e;
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL %s_count got %0d outputs, need %0d", tag, got_d.size(), exp_d.size());
    end
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      t = exp_d[i];
      e = t[11:0];
      checks++;
      if (got_d[i] !== e || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL %s_out[%0d] got data=%0d last=%0b, need data=%0d last=%0b",
                 tag, i, $signed(got_d[i]), got_l[i], t, exp_l[i]);
      end
    end
    got_d.delete();
    got_l.delete();
    exp_d.delete();
    exp_l.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 12'h000 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got valid=%0b data=%0d last=%0b in_ready=%0b, need 0 0 0 1",
               out_valid, out_data, out_last, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_mean();
    int px [8] = '{256, 512, 0, 0, 256, 0, 0, 4};
    for (int i = 0; i < 8; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = px[i][11:0];
      @(negedge clk);
      checks++;
      if (s_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_in_ready[%0d] got %0b, need 1", i, s_in_ready);
      end
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (s_got_d.size() != 2) begin
      errors++;
      $display("FAIL basic_count got %0d outputs, need 2", s_got_d.size());
    end else begin
      checks++;
      if (s_got_d[0] !== 12'd256 || s_got_l[0] !== 1'b0) begin
        errors++;
        $display("FAIL basic_out0 got data=%0d last=%0b, need 256 0", $signed(s_got_d[0]), s_got_l[0]);
      end
      checks++;
      if (s_got_d[1] !== 12'd1 || s_got_l[1] !== 1'b1) begin
        errors++;
        $display("FAIL basic_out1 got data=%0d last=%0b, need 1 1", $signed(s_got_d[1]), s_got_l[1]);
      end
    end
  endtask

  task automatic test_rounding();
    int          want [4] = '{-1, -2, 2047, -2048};
    int          t;
    logic [11:0] e;
    set_ready(0);
    random_frame();
    set_block(0, 0, -1, -1, -1, -2);
    set_block(1, 0, -2, -2, -2, -2);
    set_block(2, 0, 2047, 2047, 2047, 2047);
    set_block(3, 0, -2048, -2048, -2048, -2048);
    add_expected();
    send_range(0, 63, 0);
    wait_outputs(16);
    for (int i = 0; i < 4; i++) begin
      t = want[i];
      e = t[11:0];
      checks++;
      if (got_d.size() <= i || got_d[i] !== e) begin
        errors++;
        $display("FAIL rounding_block%0d got %0d, need %0d", i,
                 (got_d.size() > i) ? int'($signed(got_d[i])) : 9999, t);
      end
    end
    compare_outputs("rounding");
  endtask

  task automatic test_backpressure();
    int          t;
    logic [11:0] e;
    set_ready(2);
    random_frame();
    add_expected();
    send_range(0, 9, 0);
    t = exp_d[0];
    e = t[11:0];
    // Offer the next pixel while the sink is stalled; it must not be taken.
    in_valid = 1'b1;
    in_data  = frame[10][11:0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e) begin
        errors++;
        $display("FAIL backpressure_hold[%0d] got valid=%0b in_ready=%0b data=%0d, need 1 0 %0d",
                 c, out_valid, in_ready, out_data, t);
      end
      @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    send_range(10, 63, 0);
    wait_outputs(16);
    compare_outputs("backpressure");
  endtask

  task automatic test_random_frames();
    set_ready(1);
    for (int f = 0; f < 3; f++) begin
      random_frame();
      add_expected();
      for (int i = 0; i < 64; i++) send(frame[i], 3);
    end
    in_valid = 1'b0;
    wait_outputs(48);
    compare_outputs("random_frames");
  endtask

  task automatic test_reset_midframe();
    set_ready(2);
    random_frame();
    send_range(0, 9, 0);
    in_valid = 1'b1;
    in_data  = frame[10][11:0];
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pending got out_valid=%0b, need 1", out_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_clear got out_valid=%0b in_ready=%0b, need 0 1", out_valid, in_ready);
    end
    checks++;
    if (got_d.size() != 0) begin
      errors++;
      $display("FAIL midreset_leak got %0d outputs, need 0", got_d.size());
    end
    got_d.delete();
    got_l.delete();
    @(posedge clk);
    #1;
    rdy_mode = 1;
    random_frame();
    add_expected();
    send_range(0, 63, 2);
    wait_outputs(16);
    compare_outputs("after_reset");
  endtask

  task automatic test_continuous();
    bit          prev;
    int          k;
    int          t;
    logic [11:0] e;
    set_ready(0);
    random_frame();
    add_expected();
    prev = 1'b0;
    k = 0;
    for (int p = 0; p <= 64; p++) begin
      if (p < 64) begin
        in_valid = 1'b1;
        in_data  = frame[p][11:0];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== prev) begin
        errors++;
        $display("FAIL continuous_timing[%0d] got in_ready=%0b out_valid=%0b, need 1 %0b",
                 p, in_ready, out_valid, prev);
      end
      if (prev) begin
        t = exp_d[k];
        e = t[11:0];
        checks++;
        if (out_data !== e) begin
          errors++;
          $display("FAIL continuous_data[%0d] got %0d, need %0d", k, $signed(out_data), t);
        end
        k++;
      end
      prev = (p < 64) && ((p / 8) % 2 == 1) && ((p % 8) % 2 == 1);
      @(posedge clk);
      #1;
    end
    wait_outputs(16);
    compare_outputs("continuous");
  endtask

  initial begin
    test_reset();
    test_basic_mean();
    test_rounding();
    test_backpressure();
    test_random_frames();
    test_reset_midframe();
    test_continuous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
